mem_request_unit: RTL

- Sits between the control unit's decoded outputs and the cache/memory port. It is the consumer end of the control unit: it takes MemRead/MemWrite/datomic/Halt and turns them into registered iREN/dREN/dWEN requests.
- Holds each data request until dhit. Tracks the LL/SC link register, including invalidation by snoops. Raises a sticky halt.
- Counts data-stall cycles for performance reporting.

---
 rtl/mem_request_unit_if.sv | 35 +++
 rtl/mem_request_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_request_unit_if.sv
// Request-side bundle of the memory request unit: decoded controls and snoops in,
// fetch/data enables, SC status, link state, halt and stall count out.
interface mem_request_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              ihit;
    logic              dhit;
    logic              MemRead;
    logic              MemWrite;
    logic              datomic;
    logic              Halt;
    logic [ADDR_W-1:0] daddr;
    logic              snoop_inv;
    logic [ADDR_W-1:0] snoop_addr;

    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic              sc_done;
    logic              sc_result;
    logic              link_valid;
    logic              halt_out;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        input  ihit, dhit, MemRead, MemWrite, datomic, Halt, daddr, snoop_inv, snoop_addr,
        output iREN, dREN, dWEN, sc_done, sc_result, link_valid, halt_out, stall_cnt
    );

    modport slave (
        output ihit, dhit, MemRead, MemWrite, datomic, Halt, daddr, snoop_inv, snoop_addr,
        input  iREN, dREN, dWEN, sc_done, sc_result, link_valid, halt_out, stall_cnt
    );
endinterface

// File: rtl/mem_request_unit.sv
// Turns decoded load/store/atomic/halt controls into registered memory requests,
// tracks the LL/SC link register and counts data-stall cycles.
module mem_request_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    mem_request_unit_if.master  bus
);

    typedef enum logic [1:0] {Run, DWait, Halted} state_t;

    state_t            stateQ, stateD;
    logic              reqReadQ, reqReadD;
    logic              reqLLQ, reqLLD;
    logic              reqSCQ, reqSCD;
    logic [ADDR_W-1:0] reqAddrQ, reqAddrD;
    logic              linkValidQ, linkValidD;
    logic [ADDR_W-1:0] linkAddrQ, linkAddrD;
    logic              scDoneQ, scDoneD;
    logic              scResultQ, scResultD;
    logic [CNT_W-1:0]  stallCntQ, stallCntD;
    logic              snoopHit;

    function automatic logic wordEq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

    assign snoopHit = bus.snoop_inv && wordEq(bus.snoop_addr, linkAddrQ);

    always_comb begin
        stateD     = stateQ;
        reqReadD   = reqReadQ;
        reqLLD     = reqLLQ;
        reqSCD     = reqSCQ;
        reqAddrD   = reqAddrQ;
        linkValidD = linkValidQ;
        linkAddrD  = linkAddrQ;
        scDoneD    = 1'b0;
        scResultD  = scResultQ;
        stallCntD  = stallCntQ;

        if (snoopHit) linkValidD = 1'b0;

        if ((bus.dREN || bus.dWEN) && !bus.dhit && stallCntQ != {CNT_W{1'b1}}) begin
            stallCntD = stallCntQ + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        unique case (stateQ)
            Run: begin
                if (bus.ihit) begin
                    if (bus.Halt) begin
                        stateD = Halted;
                    end else if (bus.MemRead) begin
                        stateD   = DWait;
                        reqReadD = 1'b1;
                        reqLLD   = bus.datomic;
                        reqSCD   = 1'b0;
                        reqAddrD = bus.daddr;
                    end else if (bus.MemWrite) begin
                        if (!bus.datomic) begin
                            stateD   = DWait;
                            reqReadD = 1'b0;
                            reqLLD   = 1'b0;
                            reqSCD   = 1'b0;
                            reqAddrD = bus.daddr;
                        end else if (linkValidQ && !snoopHit && wordEq(linkAddrQ, bus.daddr)) begin
                            // Success is decided at issue and held until dhit.
                            stateD    = DWait;
                            reqReadD  = 1'b0;
                            reqLLD    = 1'b0;
                            reqSCD    = 1'b1;
                            reqAddrD  = bus.daddr;
                            scResultD = 1'b1;
                        end else begin
                            scDoneD = 1'b1;
                        end
                    end
                end
            end
            DWait: begin
                if (bus.dhit) begin
                    stateD    = Run;
                    scResultD = 1'b0;
                    if (reqSCQ || (!reqReadQ && wordEq(reqAddrQ, linkAddrQ))) begin
                        linkValidD = 1'b0;
                    end
                    // A completing LL overrides any clear of the old link this cycle.
                    if (reqReadQ && reqLLQ) begin
                        linkValidD = 1'b1;
                        linkAddrD  = reqAddrQ;
                    end
                end
            end
            Halted: ;
            default: stateD = Run;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ     <= Run;
            reqReadQ   <= 1'b0;
            reqLLQ     <= 1'b0;
            reqSCQ     <= 1'b0;
            reqAddrQ   <= '0;
            linkValidQ <= 1'b0;
            linkAddrQ  <= '0;
            scDoneQ    <= 1'b0;
            scResultQ  <= 1'b0;
            stallCntQ  <= '0;
        end else begin
            stateQ     <= stateD;
            reqReadQ   <= reqReadD;
            reqLLQ     <= reqLLD;
            reqSCQ     <= reqSCD;
            reqAddrQ   <= reqAddrD;
            linkValidQ <= linkValidD;
            linkAddrQ  <= linkAddrD;
            scDoneQ    <= scDoneD;
            scResultQ  <= scResultD;
            stallCntQ  <= stallCntD;
        end
    end

    assign bus.iREN       = (stateQ == Run);
    assign bus.dREN       = (stateQ == DWait) && reqReadQ;
    assign bus.dWEN       = (stateQ == DWait) && !reqReadQ;
    assign bus.halt_out   = (stateQ == Halted);
    assign bus.sc_done    = scDoneQ;
    assign bus.sc_result  = scResultQ;
    assign bus.link_valid = linkValidQ;
    assign bus.stall_cnt  = stallCntQ;

endmodule
